// File: rtl/riscv_types.sv
// Shared EXE-stage types: multiplier side-band bus and the FP result buffer entry.
package riscv_types;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_we;
        logic       fp_dest;
        logic [7:0] rob_tag;
    } exe_p_mux_bus_type;

    typedef struct packed {
        logic [31:0]       result;
        exe_p_mux_bus_type bus;
    } fp_res_entry_t;

    localparam int FP_RES_DEPTH_DEF = 4;

endpackage

// File: rtl/fp_mul_result_buffer_mem.sv
// DEPTH x fp_res_entry_t storage for the FP result buffer: one write port, asynchronous read port.
module fp_res_fifo_mem
    import riscv_types::*;
#(
    parameter  int DEPTH = FP_RES_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fp_res_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fp_res_entry_t rdata_o
);

    fp_res_entry_t mem_q [DEPTH];

    // NOTE: storage is reset so an empty buffer presents zero result/bus after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Result FIFO behind the FP multiplier with credit-based mul_en backpressure.
// Define FP_RES_BYPASS_EN for a zero-latency path when the buffer is empty.
module fp_mul_result_buffer
    import riscv_types::*;
#(
    parameter  int DEPTH = FP_RES_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [31:0]       in_result,
    input  exe_p_mux_bus_type in_bus,
    output logic              mul_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output exe_p_mux_bus_type out_bus,
    output logic [OW-1:0]     occupancy,
    output logic              ovf_err
);

    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d, occ_next;
    logic          fresh_q;
    logic          ovf_q, ovf_d;
    logic          push, pop, full, byp_hit, fifo_we, fifo_re;
    fp_res_entry_t wr_entry, rd_entry;

    // A result held by a stalled multiplier was already pushed; only fresh ones count.
    assign push     = in_valid & fresh_q;
    assign full     = (occ_q == DEPTH_W);
    assign wr_entry = '{result: in_result, bus: in_bus};

`ifdef FP_RES_BYPASS_EN
    assign byp_hit = push & (occ_q == '0);
`else
    assign byp_hit = 1'b0;
`endif

    assign out_valid  = (occ_q != '0) | byp_hit;
    assign out_result = byp_hit ? in_result : rd_entry.result;
    assign out_bus    = byp_hit ? in_bus    : rd_entry.bus;
    assign pop        = out_valid & out_ready;

    // A bypassed entry consumed this cycle never touches storage.
    assign fifo_we  = push & ~full & ~(byp_hit & out_ready);
    assign fifo_re  = pop & ~byp_hit;
    assign occ_next = occ_q + OW'(fifo_we) - OW'(fifo_re);

    // Credit: leave room for the op launched now, which lands next cycle.
    assign mul_en = clear | (occ_next < DEPTH_W);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (fifo_we) wr_ptr_d = wr_ptr_q + 1'b1;
            if (fifo_re) rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d = occ_next;
            if (push & full) ovf_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            fresh_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            fresh_q  <= clear ? 1'b0 : mul_en;
        end
    end

    fp_res_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (fifo_we & ~clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign occupancy = occ_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Self-checking bench for fp_mul_result_buffer: directed scenarios plus random traffic vs a queue model.
module tb_fp_mul_result_buffer;
    import riscv_types::*;

    localparam int DEPTH = FP_RES_DEPTH_DEF;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic [31:0]       in_result;
    exe_p_mux_bus_type in_bus;
    logic              mul_en;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    exe_p_mux_bus_type out_bus;
    logic [OW-1:0]     occupancy;
    logic              ovf_err;

    int checks = 0;
    int errors = 0;

    fp_mul_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_bus     (in_bus),
        .mul_en     (mul_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_bus    (out_bus),
        .occupancy  (occupancy),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue; the multiplier delivers a new
    // result only if it was enabled in the previous cycle.
    fp_res_entry_t mq[$];
    bit            m_fresh;
    bit            byp;

    initial begin
        byp = 1'b0;
`ifdef FP_RES_BYPASS_EN
        byp = 1'b1;
`endif
    end

    always @(negedge clk) begin
        bit            m_push, m_pop, m_valid, m_en;
        int            m_next;
        fp_res_entry_t head, incoming;
        if (!rst) begin
            mq.delete();
            m_fresh = 1'b0;
        end else begin
            incoming.result = in_result;
            incoming.bus    = in_bus;
            m_push  = in_valid && m_fresh;
            m_valid = (mq.size() != 0) || (byp && m_push);
            head    = (mq.size() != 0) ? mq[0] : incoming;
            m_pop   = m_valid && out_ready;
            m_next  = mq.size() + int'(m_push) - int'(m_pop);
            m_en    = clear || (m_next < DEPTH);

            check("mdl_out_valid", 64'(out_valid), 64'(m_valid));
            check("mdl_mul_en",    64'(mul_en),    64'(m_en));
            check("mdl_occupancy", 64'(occupancy), 64'(mq.size()));
            check("mdl_ovf_err",   64'(ovf_err),   64'd0);
            if (m_valid) begin
                check("mdl_out_result", 64'(out_result), 64'(head.result));
                check("mdl_out_bus",    64'(out_bus),    64'(head.bus));
            end

            if (clear) begin
                mq.delete();
                m_fresh = 1'b0;
            end else begin
                if (m_push) mq.push_back(incoming);
                if (m_pop) void'(mq.pop_front());
                m_fresh = m_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [14:0] bus,
                         input logic rdy, input logic clr);
        in_valid  = v;
        in_result = res;
        in_bus    = bus;
        out_ready = rdy;
        clear     = clr;
    endtask

    logic [31:0] stream [4];
    logic [31:0] drain4 [4];
    logic [14:0] rnd_bus;

    initial begin
        stream[0] = 32'h4000_0000; stream[1] = 32'h4040_0000;
        stream[2] = 32'h4080_0000; stream[3] = 32'h40A0_0000;
        drain4[0] = 32'h4110_0000; drain4[1] = 32'h4120_0000;
        drain4[2] = 32'h4130_0000; drain4[3] = 32'hC000_0000;

        rst = 1'b0;
        drive(1'b0, 32'h0, 15'h0, 1'b1, 1'b0);
        #2;
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_occupancy",  64'(occupancy),  64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_bus",    64'(out_bus),    64'd0);
        check("rst_ovf_err",    64'(ovf_err),    64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: single push of 1.0 with the result mux ready
        tick();
        drive(1'b1, 32'h3F80_0000, 15'h1234, 1'b1, 1'b0);
`ifdef FP_RES_BYPASS_EN
        @(negedge clk);
        check("t1_byp_valid",  64'(out_valid),  64'd1);
        check("t1_byp_result", 64'(out_result), 64'h3F80_0000);
        check("t1_byp_occ",    64'(occupancy),  64'd0);
`endif
        tick();
        drive(1'b0, 32'h0, 15'h0, 1'b1, 1'b0);
`ifndef FP_RES_BYPASS_EN
        @(negedge clk);
        check("t1_valid",  64'(out_valid),  64'd1);
        check("t1_result", 64'(out_result), 64'h3F80_0000);
        check("t1_bus",    64'(out_bus),    64'h1234);
`endif
        tick();

        // 2: stream four values into a stalled writeback
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream[i], 15'(i), 1'b0, 1'b0);
            @(negedge clk);
            check("t2_mul_en", 64'(mul_en), (i < 3) ? 64'd1 : 64'd0);
            tick();
        end
        drive(1'b0, 32'h0, 15'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_occ_full", 64'(occupancy), 64'd4);
        check("t2_mul_en",   64'(mul_en),    64'd0);
        check("t2_ovf",      64'(ovf_err),   64'd0);
        tick();

        // 3: drain in order, one per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 15'h0, 1'b1, 1'b0);
            @(negedge clk);
            check("t3_valid",  64'(out_valid),  64'd1);
            check("t3_result", 64'(out_result), 64'(stream[i]));
            check("t3_mul_en", 64'(mul_en),     64'd1);
            tick();
        end
        @(negedge clk);
        check("t3_empty", 64'(out_valid), 64'd0);
        tick();

        // 4: stale held output is not re-pushed while mul_en is low
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, drain4[i], 15'h0, 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 32'hC000_0000, 15'h7ABC, 1'b0, 1'b0);
            @(negedge clk);
            check("t4_mul_en", 64'(mul_en), 64'd0);
            tick();
        end
        drive(1'b0, 32'h0, 15'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_occ", 64'(occupancy), 64'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 15'h0, 1'b1, 1'b0);
            @(negedge clk);
            check("t4_drain", 64'(out_result), 64'(drain4[i]));
            tick();
        end
        @(negedge clk);
        check("t4_single_push", 64'(out_valid), 64'd0);
        tick();

        // 5: clear beats a simultaneous push and pop
        drive(1'b1, 32'h3E00_0000, 15'h1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3E80_0000, 15'h2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h7F00_0000, 15'h3, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_occ_pre",   64'(occupancy), 64'd2);
        check("t5_en_clear",  64'(mul_en),    64'd1);
        tick();
        drive(1'b0, 32'h0, 15'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_occ",    64'(occupancy), 64'd0);
        check("t5_valid",  64'(out_valid), 64'd0);
        check("t5_mul_en", 64'(mul_en),    64'd1);
        tick();

        // 6: asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4200_0000 + 32'(i), 15'h55, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 15'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t6_valid",  64'(out_valid),  64'd0);
        check("t6_occ",    64'(occupancy),  64'd0);
        check("t6_result", 64'(out_result), 64'd0);
        check("t6_bus",    64'(out_bus),    64'd0);
        tick();
        rst = 1'b1;
        tick();
        drive(1'b1, 32'h1234_5678, 15'h0F0F, 1'b1, 1'b0);
`ifdef FP_RES_BYPASS_EN
        @(negedge clk);
        check("t6_byp_result", 64'(out_result), 64'h1234_5678);
`endif
        tick();
        drive(1'b0, 32'h0, 15'h0, 1'b1, 1'b0);
`ifndef FP_RES_BYPASS_EN
        @(negedge clk);
        check("t6_next_valid",  64'(out_valid),  64'd1);
        check("t6_next_result", 64'(out_result), 64'h1234_5678);
`endif
        tick();

        // Random traffic checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            rnd_bus = 15'($urandom);
            drive(($urandom_range(0, 9) < 7), $urandom, rnd_bus,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
            tick();
        end

        drive(1'b0, 32'h0, 15'h0, 1'b0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
